sweep_count_ctrl: RTL and testbench
===================================

SWEEP_COUNT_CTRL -- requirements
Module: sweep_count_ctrl

Interface
REQ-001 Parameter: HOLD_CYCLES, 2, number of cycles the count dwells at the upper limit (legal 1..15).
REQ-002 Port: clk  input  1  single clock; all state updates on posedge clk.
REQ-003 Port: rst  input  1  reset; synchronous and active-high.
REQ-004 Port: start  input  1  request a sweep; sampled only in IDLE.
REQ-005 Port: abort  input  1  cancel an in-progress sweep.
REQ-006 Port: lo  input  4  lower sweep limit; captured on an accepted start.
REQ-007 Port: hi  input  4  upper sweep limit; captured on an accepted start.
REQ-008 Port: passes  input  3  number of up/down passes; captured on an accepted start; 0 is treated as 1.
REQ-009 Port: count  output  4  current counter value.
REQ-010 Port: busy  output  1  high in the LOAD, UP, HOLD and DOWN states.
REQ-011 Port: done  output  1  one-cycle pulse on normal completion.
REQ-012 Port: err  output  1  one-cycle pulse on a rejected start.

Function
REQ-013 The FSM SHALL have the states IDLE, LOAD, UP, HOLD, DOWN and DONE; count, done and err SHALL be registered.
REQ-014 In IDLE, start=1 with lo<=hi SHALL capture lo, hi and passes, and SHALL move to LOAD.
REQ-015 In IDLE, start=1 with lo>hi SHALL pulse err for one cycle, SHALL stay in IDLE, and SHALL leave count unchanged.
REQ-016 LOAD SHALL last one cycle, SHALL load count<=lo, and SHALL then move to UP.
REQ-017 UP: if count<hi, count SHALL increment by 1; if count==hi, count SHALL hold and the FSM SHALL move to HOLD.
REQ-018 HOLD SHALL last exactly HOLD_CYCLES cycles with count stable, then move to DOWN.
REQ-019 DOWN: if count>lo, count SHALL decrement by 1; if count==lo, count SHALL hold and the remaining-pass count SHALL decrement.
REQ-020 At DOWN exit, if passes remain the FSM SHALL go to UP; otherwise it SHALL go to DONE.
REQ-021 DONE SHALL last one cycle with done=1 and busy=0, SHALL return to IDLE, and count SHALL retain its final value (lo).
REQ-022 Because lo<=hi is enforced, count SHALL never wrap; the sub-module's modulo-16 wrap SHALL be unreachable.
REQ-023 lo==hi SHALL be legal: UP exits on its first cycle, and HOLD and DOWN proceed normally.
REQ-024 lo=0 with hi=15 SHALL sweep the full range without wrap.
REQ-025 start while busy SHALL be ignored, with no err pulse and no recapture of lo, hi or passes.
REQ-026 abort=1 in any non-IDLE state SHALL return the FSM to IDLE next cycle, SHALL freeze count, and SHALL suppress done.
REQ-027 abort in IDLE SHALL have no effect.
REQ-028 start and abort together in IDLE SHALL be treated as start only.
REQ-029 Changes to lo, hi or passes during a sweep SHALL have no effect.

Reset
REQ-030 rst=1 SHALL force state IDLE, count=0, busy=0, done=0, err=0, captured limits=0 and remaining-pass count=0 at the next posedge clk.
REQ-031 rst SHALL override start and abort, including when asserted mid-sweep.
REQ-032 The first start after rst deasserts SHALL be accepted normally.

Structure
REQ-033 A shared package SHALL hold the FSM state enum, the counter width constant (4) and the pass-count width constant (3).
REQ-034 A single sub-module, updown_counter4, SHALL implement the counter: 4-bit, synchronous loadable, up/down, with priority rst > load > up > down.
REQ-035 sweep_count_ctrl SHALL drive updown_counter4's load, up and down controls from the FSM and SHALL not modify count elsewhere.
REQ-036 HOLD_CYCLES SHALL be counted by a local 4-bit down-counter.

Verification
REQ-037 Scenario: lo=3, hi=5, passes=1, HOLD_CYCLES=2, start pulse -> count over successive cycles after LOAD is 3,4,5,5,5,5,4,3, then done=1 for one cycle with count=3 and busy=0.
REQ-038 Scenario: lo=2, hi=3, passes=2 -> count is 2,3,3,3,3,2 twice in succession, with exactly one done pulse after the second pass.
REQ-039 Scenario: lo=9, hi=4, start -> err=1 for one cycle, busy stays 0, count unchanged.
REQ-040 Scenario: abort asserted during HOLD with count=5 -> IDLE next cycle, count stays 5, no done pulse; a following start is accepted.
REQ-041 Scenario: start held high during a sweep while lo and hi change -> the sweep uses the originally captured limits, no err pulse.
REQ-042 Scenario: rst asserted during UP with count=4 -> next cycle count=0, busy=0, state IDLE; lo=0, hi=15, passes=0 then sweeps 0..15..0 once without wrap.

Source files
------------

// File: rtl/sweep_count_ctrl_pkg.sv
// ============================================================================
// Module      : sweep_count_ctrl_pkg
// Description : Shared widths and FSM state encoding for the sweep controller.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package sweep_count_ctrl_pkg;

    localparam int c_CNT_W  = 4;
    localparam int c_PASS_W = 3;
    localparam int c_HOLD_W = 4;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_UP   = 3'd2,
        S_HOLD = 3'd3,
        S_DOWN = 3'd4,
        S_DONE = 3'd5
    } state_t;

endpackage

`default_nettype wire

// File: rtl/updown_counter4.sv
// ============================================================================
// Module      : updown_counter4
// Description : 4-bit synchronous loadable up/down counter, rst > load > up > down.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module updown_counter4
    import sweep_count_ctrl_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               i_load,
    input  logic               i_up,
    input  logic               i_down,
    input  logic [c_CNT_W-1:0] i_d,
    output logic [c_CNT_W-1:0] o_q
);

    logic [c_CNT_W-1:0] r_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q <= '0;
        end else if (i_load) begin
            r_q <= i_d;
        end else if (i_up) begin
            r_q <= r_q + 1'b1;
        end else if (i_down) begin
            r_q <= r_q - 1'b1;
        end
    end

    assign o_q = r_q;

endmodule

`default_nettype wire

// File: rtl/sweep_count_ctrl.sv
// ============================================================================
// Module      : sweep_count_ctrl
// Description : Sweeps a counter lo->hi, dwells, then hi->lo for N passes.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module sweep_count_ctrl
    import sweep_count_ctrl_pkg::*;
#(
    parameter int HOLD_CYCLES = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                abort,
    input  logic [c_CNT_W-1:0]  lo,
    input  logic [c_CNT_W-1:0]  hi,
    input  logic [c_PASS_W-1:0] passes,
    output logic [c_CNT_W-1:0]  count,
    output logic                busy,
    output logic                done,
    output logic                err
);

    state_t                r_state;
    state_t                w_next;
    logic [c_CNT_W-1:0]    r_lo;
    logic [c_CNT_W-1:0]    r_hi;
    logic [c_PASS_W-1:0]   r_rem;
    logic [c_HOLD_W-1:0]   r_hold;
    logic                  r_done;
    logic                  r_err;

    logic                  w_accept;
    logic                  w_reject;
    logic                  w_at_hi;
    logic                  w_at_lo;
    logic                  w_load;
    logic                  w_up;
    logic                  w_down;
    logic                  w_busy;

    assign w_accept = (r_state == S_IDLE) && start && (lo <= hi);
    assign w_reject = (r_state == S_IDLE) && start && (lo > hi);
    assign w_at_hi  = (count == r_hi);
    assign w_at_lo  = (count == r_lo);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (w_accept) w_next = S_LOAD;
            S_LOAD: w_next = S_UP;
            S_UP:   if (w_at_hi) w_next = S_HOLD;
            S_HOLD: if (r_hold == '0) w_next = S_DOWN;
            S_DOWN: if (w_at_lo) w_next = (r_rem > c_PASS_W'(1)) ? S_UP : S_DONE;
            S_DONE: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
        // Abort wins over every transition except from IDLE, where start has priority.
        if (abort && (r_state != S_IDLE)) begin
            w_next = S_IDLE;
        end
    end

    always_comb begin
        w_load = 1'b0;
        w_up   = 1'b0;
        w_down = 1'b0;
        w_busy = 1'b0;
        case (r_state)
            S_LOAD: begin
                w_load = !abort;
                w_busy = 1'b1;
            end
            S_UP: begin
                w_up   = !abort && !w_at_hi;
                w_busy = 1'b1;
            end
            S_HOLD: w_busy = 1'b1;
            S_DOWN: begin
                w_down = !abort && !w_at_lo;
                w_busy = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_lo   <= '0;
            r_hi   <= '0;
            r_rem  <= '0;
            r_hold <= '0;
            r_done <= 1'b0;
            r_err  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_lo  <= lo;
                r_hi  <= hi;
                r_rem <= (passes == '0) ? c_PASS_W'(1) : passes;
            end else if ((r_state == S_DOWN) && w_at_lo && !abort) begin
                r_rem <= r_rem - 1'b1;
            end
            if ((r_state == S_UP) && w_at_hi) begin
                r_hold <= c_HOLD_W'(HOLD_CYCLES - 1);
            end else if ((r_state == S_HOLD) && (r_hold != '0)) begin
                r_hold <= r_hold - 1'b1;
            end
            r_done <= (w_next == S_DONE);
            r_err  <= w_reject;
        end
    end

    updown_counter4 u_counter (
        .clk    (clk),
        .rst    (rst),
        .i_load (w_load),
        .i_up   (w_up),
        .i_down (w_down),
        .i_d    (r_lo),
        .o_q    (count)
    );

    assign busy = w_busy;
    assign done = r_done;
    assign err  = r_err;

endmodule

`default_nettype wire

// File: tb/tb_sweep_count_ctrl.sv
// ============================================================================
// Module      : tb_sweep_count_ctrl
// Description : Scoreboard bench; expected per-cycle outputs come from a sweep profile model.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_sweep_count_ctrl;

    localparam int HOLD = 2;
    localparam int c_WATCHDOG_CYCLES = 200000;

    typedef struct packed {
        logic [3:0] cnt;
        logic       busy;
        logic       done;
        logic       err;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       abort;
    logic [3:0] lo;
    logic [3:0] hi;
    logic [2:0] passes;
    logic [3:0] count;
    logic       busy;
    logic       done;
    logic       err;

    exp_t       sb[$];
    exp_t       mon_e;
    int         checks = 0;
    int         errors = 0;
    int         cyc    = 0;
    logic [3:0] m_count;

    always #5 clk = ~clk;

    sweep_count_ctrl #(.HOLD_CYCLES(HOLD)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .abort  (abort),
        .lo     (lo),
        .hi     (hi),
        .passes (passes),
        .count  (count),
        .busy   (busy),
        .done   (done),
        .err    (err)
    );

    // Monitor: one expectation per clock edge, compared just after the edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (sb.size() > 0) begin
                mon_e = sb.pop_front();
                checks++;
                if ({count, busy, done, err} !== {mon_e.cnt, mon_e.busy, mon_e.done, mon_e.err}) begin
                    errors++;
                    $display("FAIL cycle %0d: got count=%0d busy=%0b done=%0b err=%0b, expected count=%0d busy=%0b done=%0b err=%0b",
                             cyc, count, busy, done, err, mon_e.cnt, mon_e.busy, mon_e.done, mon_e.err);
                end
            end
        end
    end

    // Watchdog: the run must complete within a bounded number of cycles.
    initial begin
        repeat (c_WATCHDOG_CYCLES) @(posedge clk);
        checks++;
        errors++;
        $display("FAIL timeout: run did not complete within %0d cycles", c_WATCHDOG_CYCLES);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    task automatic step(input logic s, input logic a, input logic r, input logic [3:0] l,
                        input logic [3:0] h, input logic [2:0] p, input exp_t e);
        @(negedge clk);
        start  = s;
        abort  = a;
        rst    = r;
        lo     = l;
        hi     = h;
        passes = p;
        sb.push_back(e);
        m_count = e.cnt;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            step(1'b0, 1'($urandom), 1'b0, 4'($urandom), 4'($urandom), 3'($urandom),
                 exp_t'{m_count, 1'b0, 1'b0, 1'b0});
        end
    endtask

    task automatic reject(input logic [3:0] l, input logic [3:0] h);
        step(1'b1, 1'($urandom), 1'b0, l, h, 3'($urandom), exp_t'{m_count, 1'b0, 1'b0, 1'b1});
        idle(1);
    endtask

    // Expected trace: LOAD, then per pass lo..hi, hi x HOLD, hi..lo, then DONE.
    task automatic sweep(input logic [3:0] l, input logic [3:0] h, input logic [2:0] p,
                         input int abort_at, input int rst_at, input bit noise);
        exp_t tr[$];
        int   np;
        int   len;
        int   li;
        int   hh;
        logic       rs;
        logic [3:0] rl;
        logic [3:0] rh;
        logic [2:0] rp;
        li = int'(l);
        hh = int'(h);
        np = (p == 3'd0) ? 1 : int'(p);
        tr.push_back(exp_t'{m_count, 1'b1, 1'b0, 1'b0});
        for (int k = 0; k < np; k++) begin
            for (int v = li; v <= hh; v++) tr.push_back(exp_t'{4'(v), 1'b1, 1'b0, 1'b0});
            for (int k2 = 0; k2 < HOLD; k2++) tr.push_back(exp_t'{h, 1'b1, 1'b0, 1'b0});
            for (int v = hh; v >= li; v--) tr.push_back(exp_t'{4'(v), 1'b1, 1'b0, 1'b0});
        end
        tr.push_back(exp_t'{l, 1'b0, 1'b1, 1'b0});
        len = tr.size();
        step(1'b1, 1'($urandom), 1'b0, l, h, p, tr[0]);
        for (int i = 1; i <= len; i++) begin
            rs = noise && (i < len);
            rl = noise ? 4'($urandom) : l;
            rh = noise ? 4'($urandom) : h;
            rp = noise ? 3'($urandom) : p;
            if (i == abort_at) begin
                step(rs, 1'b1, 1'b0, rl, rh, rp, exp_t'{tr[i-1].cnt, 1'b0, 1'b0, 1'b0});
                return;
            end
            if (i == rst_at) begin
                step(rs, 1'($urandom), 1'b1, rl, rh, rp, exp_t'{4'd0, 1'b0, 1'b0, 1'b0});
                return;
            end
            step(rs, 1'b0, 1'b0, rl, rh, rp,
                 (i < len) ? tr[i] : exp_t'{l, 1'b0, 1'b0, 1'b0});
        end
    endtask

    initial begin
        int         kind;
        logic [3:0] a;
        logic [3:0] b;
        rst     = 1'b1;
        start   = 1'b0;
        abort   = 1'b0;
        lo      = '0;
        hi      = '0;
        passes  = '0;
        m_count = '0;
        sb.push_back(exp_t'{4'd0, 1'b0, 1'b0, 1'b0});
        step(1'b1, 1'b1, 1'b1, 4'd1, 4'd2, 3'd1, exp_t'{4'd0, 1'b0, 1'b0, 1'b0});
        @(posedge clk);
        #2;
        checks++;
        if ({count, busy, done, err} !== {4'd0, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset state: count=%0d busy=%0b done=%0b err=%0b, expected all zero",
                     count, busy, done, err);
        end
        idle(2);

        sweep(4'd3, 4'd5, 3'd1, -1, -1, 1'b0);
        idle(2);
        sweep(4'd2, 4'd3, 3'd2, -1, -1, 1'b0);
        idle(1);
        reject(4'd9, 4'd4);
        sweep(4'd3, 4'd5, 3'd1, 5, -1, 1'b0);
        sweep(4'd1, 4'd2, 3'd1, -1, -1, 1'b0);
        sweep(4'd4, 4'd7, 3'd3, -1, -1, 1'b1);
        idle(1);
        sweep(4'd3, 4'd8, 3'd1, -1, 3, 1'b0);
        idle(1);
        sweep(4'd0, 4'd15, 3'd0, -1, -1, 1'b0);
        sweep(4'd6, 4'd6, 3'd1, -1, -1, 1'b0);
        idle(1);

        for (int t = 0; t < 40; t++) begin
            kind = int'($urandom_range(0, 5));
            if (kind == 0) begin
                a = 4'($urandom_range(1, 15));
                b = 4'($urandom_range(0, int'(a) - 1));
                reject(a, b);
            end else begin
                a = 4'($urandom);
                b = 4'($urandom);
                if (a > b) begin
                    a = a ^ b;
                    b = a ^ b;
                    a = a ^ b;
                end
                sweep(a, b, 3'($urandom),
                      (kind == 1) ? int'($urandom_range(1, 30)) : -1,
                      (kind == 2) ? int'($urandom_range(1, 30)) : -1,
                      1'($urandom));
                idle(int'($urandom_range(0, 2)));
            end
        end

        idle(3);
        @(posedge clk);
        #2;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations were never checked", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
